rob_wb_arbiter: RTL

//  Shares the single ROB writeback port (wr1_en/wr1_addr/wr1_data) among NUM_REQ execution units.

---
 rtl/rob_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/rob_wb_arbiter.sv | 70 +++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared ROB geometry constants and the ceiling-log2 helper
package rob_pkg;
    function automatic int clogb(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    localparam int ROB_WIDTH    = 26;
    localparam int ENTRY_NUM    = 21;
    localparam int IDX_W        = clogb(ENTRY_NUM);
    localparam int ROB_DONE_BIT = 0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, ascending with wrap
module rr_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PW = clogb(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [PW-1:0]      grant_idx,
    output logic               any
);
    // first requester at or after ptr wins; modulo keeps non-power-of-2 counts legal
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [PW-1:0] j;
            j = PW'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[j]) begin
                any       = 1'b1;
                grant_idx = j;
            end
        end
        grant_onehot[grant_idx] = any;
    end
endmodule

// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: shares the single ROB writeback port among NUM_REQ units
module rob_wb_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH,
    parameter int ENTRY_NUM = rob_pkg::ENTRY_NUM,
    localparam int IDX_W = clogb(ENTRY_NUM),
    localparam int PW    = clogb(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*IDX_W-1:0]       req_addr_i,
    input  logic [NUM_REQ*ROB_WIDTH-1:0]   req_data_i,
    output logic                           wr_en_o,
    output logic [IDX_W-1:0]               wr_addr_o,
    output logic [ROB_WIDTH-1:0]           wr_data_o,
    output logic [PW-1:0]                  grant_id_o,
    output logic                           err_o
);
    logic [PW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [PW-1:0]        grant_idx;
    logic                 any;
    logic                 xfer;
    logic                 bad;
    logic [IDX_W-1:0]     sel_addr;
    logic [ROB_WIDTH-1:0] sel_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req          (req_valid_i),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any)
    );

    // flush and reset both kill this cycle's grant; out-of-range indices are still accepted
    always_comb begin
        req_ready_o = (rst || flush_i) ? '0 : grant_onehot;
        xfer        = any && !rst && !flush_i;
        sel_addr    = req_addr_i[grant_idx*IDX_W +: IDX_W];
        sel_data    = req_data_i[grant_idx*ROB_WIDTH +: ROB_WIDTH];
        bad         = int'(sel_addr) >= ENTRY_NUM;
    end

    // pointer advance, registered write port and sticky range error
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            grant_id_o <= '0;
            err_o      <= 1'b0;
        end else begin
            wr_en_o <= xfer && !bad;
            if (xfer) rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (xfer && !bad) begin
                wr_addr_o  <= sel_addr;
                wr_data_o  <= sel_data;
                grant_id_o <= grant_idx;
            end
            if (xfer && bad) err_o <= 1'b1;
        end
    end
endmodule
